// File: rtl/spin_sweep_engine_if.sv
// Port bundle for spin_sweep_engine: run control, spin vectors, the
// weight-row fetch handshake and the run results.
interface spin_sweep_engine_if #(
  parameter int NUM_SPIN     = 60,
  parameter int WORD_WIDTH   = 4,
  parameter int MAX_SWEEPS   = 8,
  parameter int ENERGY_WIDTH = 20
);
  localparam int AW = (NUM_SPIN > 1) ? $clog2(NUM_SPIN) : 1;
  localparam int SW = $clog2(MAX_SWEEPS + 1);

  logic                             start;
  logic                             bypass;
  logic                             stop;
  logic [NUM_SPIN-1:0]              spins_in;
  logic                             row_req;
  logic [AW-1:0]                    row_addr;
  logic                             row_valid;
  logic [WORD_WIDTH*NUM_SPIN-1:0]   row_weight;
  logic [WORD_WIDTH*NUM_SPIN-1:0]   col_weight;
  logic                             busy;
  logic                             done;
  logic [NUM_SPIN-1:0]              spins_out;
  logic [ENERGY_WIDTH-1:0]          energy_out;
  logic [15:0]                      flip_count;
  logic [SW-1:0]                    sweeps_done;

  modport master (
    output start, bypass, stop, spins_in, row_valid, row_weight, col_weight,
    input  row_req, row_addr, busy, done, spins_out, energy_out, flip_count, sweeps_done
  );

  modport slave (
    input  start, bypass, stop, spins_in, row_valid, row_weight, col_weight,
    output row_req, row_addr, busy, done, spins_out, energy_out, flip_count, sweeps_done
  );
endinterface

// File: rtl/spin_sweep_engine.sv
// Greedy Gauss-Seidel spin sweeps followed by one energy pass; weights arrive
// one row (plus matching column) per fetch and are reduced CHUNK terms per cycle.
module spin_sweep_engine #(
  parameter int NUM_SPIN     = 60,
  parameter int WORD_WIDTH   = 4,
  parameter int CHUNK        = 30,
  parameter int MAX_SWEEPS   = 8,
  parameter int ENERGY_WIDTH = 20
) (
  input  logic               clk,
  input  logic               reset,
  spin_sweep_engine_if.slave io
);
  localparam int CHUNKS = NUM_SPIN / CHUNK;
  localparam int AW     = (NUM_SPIN > 1) ? $clog2(NUM_SPIN) : 1;
  localparam int SW     = $clog2(MAX_SWEEPS + 1);
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PW     = WORD_WIDTH + 1;
  localparam int HW     = WORD_WIDTH + 1 + $clog2(NUM_SPIN);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC, S_UPDATE, S_EACC, S_DONE} state_t;

  state_t                   r_state, w_state_next;
  logic                     r_mode_energy;
  logic [AW-1:0]            r_row;
  logic [CW-1:0]            r_chunk;
  logic [NUM_SPIN-1:0]      r_spins;
  logic signed [HW-1:0]     r_field;
  logic                     r_sweep_flipped;
  logic [15:0]              r_flip_count;
  logic [SW-1:0]            r_sweeps;
  logic signed [ENERGY_WIDTH-1:0] r_energy;

  logic signed [HW-1:0]     w_term [NUM_SPIN];
  logic signed [HW-1:0]     w_part [CHUNKS];
  logic signed [HW-1:0]     w_chunk_sum, w_e_term;
  logic signed [ENERGY_WIDTH-1:0] w_e_ext;
  logic                     w_new_bit, w_old_bit, w_flip, w_last_row, w_last_chunk;
  logic                     w_any_flip, w_to_energy;
  logic [SW-1:0]            w_sweeps_inc;
  logic                     w_busy, w_done, w_row_req;

  // Per spin: latch Jr+Jc (diagonal masked) on the fetch, then apply sigma_j.
  genvar gi;
  for (gi = 0; gi < NUM_SPIN; gi++) begin : g_spin
    logic signed [WORD_WIDTH-1:0] w_jr, w_jc;
    logic signed [PW-1:0]         w_pair, r_wsum;
    logic signed [HW-1:0]         w_wext;
    assign w_jr   = io.row_weight[gi*WORD_WIDTH +: WORD_WIDTH];
    assign w_jc   = io.col_weight[gi*WORD_WIDTH +: WORD_WIDTH];
    assign w_pair = (r_row == AW'(gi)) ? '0
                  : ({w_jr[WORD_WIDTH-1], w_jr} + {w_jc[WORD_WIDTH-1], w_jc});
    always_ff @(posedge clk) begin
      if (r_state == S_FETCH && io.row_valid) r_wsum <= w_pair;
    end
    assign w_wext     = {{(HW-PW){r_wsum[PW-1]}}, r_wsum};
    assign w_term[gi] = r_spins[gi] ? -w_wext : w_wext;
  end

  for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
    logic signed [HW-1:0] w_acc;
    always_comb begin
      w_acc = '0;
      for (int c = 0; c < CHUNK; c++) w_acc = w_acc + w_term[gi*CHUNK + c];
    end
    assign w_part[gi] = w_acc;
  end

  assign w_chunk_sum  = w_part[r_chunk];
  assign w_last_chunk = (r_chunk == CW'(CHUNKS - 1));
  assign w_last_row   = (r_row == AW'(NUM_SPIN - 1));
  assign w_old_bit    = r_spins[r_row];
  assign w_new_bit    = ~r_field[HW-1];
  assign w_flip       = (w_new_bit != w_old_bit);
  assign w_any_flip   = r_sweep_flipped | w_flip;
  assign w_sweeps_inc = r_sweeps + 1'b1;
  // stop ends the sweep phase right after this row's write, even mid-sweep.
  assign w_to_energy  = io.stop |
                        (w_last_row & (~w_any_flip | (w_sweeps_inc == SW'(MAX_SWEEPS))));
  assign w_e_term     = w_old_bit ? -r_field : r_field;
  assign w_e_ext      = {{(ENERGY_WIDTH-HW){w_e_term[HW-1]}}, w_e_term};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (io.start) w_state_next = S_FETCH;
      S_FETCH:  if (io.row_valid) w_state_next = S_ACC;
      S_ACC:    if (w_last_chunk) w_state_next = r_mode_energy ? S_EACC : S_UPDATE;
      S_UPDATE: w_state_next = S_FETCH;
      S_EACC:   w_state_next = w_last_row ? S_DONE : S_FETCH;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_done    = (r_state == S_DONE);
    w_row_req = (r_state == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_energy   <= 1'b0;
      r_row           <= '0;
      r_chunk         <= '0;
      r_spins         <= '0;
      r_field         <= '0;
      r_sweep_flipped <= 1'b0;
      r_flip_count    <= '0;
      r_sweeps        <= '0;
      r_energy        <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (io.start) begin
          r_spins         <= io.spins_in;
          r_mode_energy   <= io.bypass;
          r_row           <= '0;
          r_sweep_flipped <= 1'b0;
          r_flip_count    <= '0;
          r_sweeps        <= '0;
          r_energy        <= '0;
        end
        S_FETCH: begin
          r_chunk <= '0;
          r_field <= '0;
        end
        S_ACC: begin
          r_field <= r_field + w_chunk_sum;
          r_chunk <= r_chunk + 1'b1;
        end
        S_UPDATE: begin
          r_spins[r_row]  <= w_new_bit;
          r_sweep_flipped <= w_any_flip;
          if (w_flip && r_flip_count != 16'hFFFF) r_flip_count <= r_flip_count + 16'd1;
          if (w_last_row) r_sweeps <= w_sweeps_inc;
          if (w_to_energy) begin
            r_mode_energy <= 1'b1;
            r_row         <= '0;
          end else if (w_last_row) begin
            r_row           <= '0;
            r_sweep_flipped <= 1'b0;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_EACC: begin
          r_energy <= r_energy + w_e_ext;
          if (!w_last_row) r_row <= r_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io.busy        = w_busy;
  assign io.done        = w_done;
  assign io.row_req     = w_row_req;
  assign io.row_addr    = r_row;
  assign io.spins_out   = r_spins;
  assign io.energy_out  = r_energy;
  assign io.flip_count  = r_flip_count;
  assign io.sweeps_done = r_sweeps;
endmodule

// File: tb/tb_spin_sweep_engine.sv
// Bench for spin_sweep_engine: acts as the weight memory and compares every
// run against an integer reference of the sweep/energy rules.
module tb_spin_sweep_engine;
  localparam int N    = 4;
  localparam int C    = 2;
  localparam int WW   = 4;
  localparam int MAXS = 2;
  localparam int EW   = 20;
  localparam int CH   = N / C;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spin_sweep_engine_if #(.NUM_SPIN(N), .WORD_WIDTH(WW), .MAX_SWEEPS(MAXS), .ENERGY_WIDTH(EW)) bus();

  spin_sweep_engine #(.NUM_SPIN(N), .WORD_WIDTH(WW), .CHUNK(C), .MAX_SWEEPS(MAXS),
                      .ENERGY_WIDTH(EW)) dut (.clk(clk), .reset(reset), .io(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  int jr [N][N];
  int jc [N][N];

  // reference results
  logic [N-1:0] m_spins;
  int m_flips, m_sweeps, m_energy;
  int m_rows[$];

  // responder / monitor shared state
  int exp_rows[$];
  int row_delay   = 0;
  int stop_serial = -1;
  bit stop_pulse  = 1'b0;
  bit mon_active  = 1'b0;
  int mon_cyc     = 0;
  int exp_done    = 0;
  int got_done    = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int field(input logic [N-1:0] s, input int i);
    int h = 0;
    for (int j = 0; j < N; j++)
      if (j != i) h += (jr[i][j] + jc[i][j]) * (s[j] ? -1 : 1);
    return h;
  endfunction

  // stop_ser: index (from 0) of the sweep row whose update sees stop high
  task automatic model(input logic [N-1:0] sp, input bit byp, input int stop_ser);
    logic [N-1:0] s = sp;
    int serial = 0;
    bit stopped = 1'b0;
    bit any;
    int h;
    int e = 0;
    m_rows.delete();
    m_flips  = 0;
    m_sweeps = 0;
    if (!byp) begin
      while (1) begin
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
          m_rows.push_back(i);
          h = field(s, i);
          if ((h >= 0) != s[i]) begin any = 1'b1; m_flips++; end
          s[i] = (h >= 0);
          if (serial == stop_ser) stopped = 1'b1;
          serial++;
          if (i == N-1) m_sweeps++;
          if (stopped) break;
        end
        if (stopped || !any || m_sweeps == MAXS) break;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_rows.push_back(i);
      h = field(s, i);
      e += s[i] ? -h : h;
    end
    m_spins  = s;
    m_energy = e;
  endtask

  // Weight memory: answers each request after row_delay extra cycles.
  int  wait_cnt = 0;
  int  serial   = 0;
  int  stop_st  = 0;
  bit  stop_lvl = 1'b0;
  logic [1:0] held_addr;
  always @(negedge clk) begin
    bus.row_valid  = 1'b0;
    bus.row_weight = (WW*N)'($urandom);
    bus.col_weight = (WW*N)'($urandom);
    if (!bus.busy) serial = 0;
    if (stop_st == 1) begin
      stop_lvl = 1'b1;
      stop_st  = stop_pulse ? 2 : 3;
    end else if (stop_st == 2 || (stop_st == 3 && bus.row_req)) begin
      stop_lvl = 1'b0;
      stop_st  = 0;
    end
    if (!bus.row_req) wait_cnt = 0;
    else begin
      if (wait_cnt > 0) chk("row_addr_stable", 32'(bus.row_addr), 32'(held_addr));
      held_addr = bus.row_addr;
      if (wait_cnt == row_delay) begin
        if (exp_rows.size() > 0) chk("row_addr", 32'(bus.row_addr), exp_rows.pop_front());
        else chk("row_extra", 32'(bus.row_addr), 32'hFFFF_FFFF);
        for (int j = 0; j < N; j++) begin
          bus.row_weight[j*WW +: WW] = WW'(jr[bus.row_addr][j]);
          bus.col_weight[j*WW +: WW] = WW'(jc[bus.row_addr][j]);
        end
        bus.row_valid = 1'b1;
        if (serial == stop_serial) stop_st = 1;
        serial++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    bus.stop = stop_lvl;
  end

  // Per-cycle compare against the reference while a run is in flight.
  always @(negedge clk) begin
    if (mon_active) begin
      mon_cyc++;
      if (bus.done && got_done < 0) got_done = mon_cyc;
      if (mon_cyc < exp_done) begin
        chk("busy_phase", {30'd0, bus.busy, bus.done}, 32'h2);
      end else begin
        chk("done_pulse", 32'(bus.done), 32'h1);
        chk("spins_out", 32'(bus.spins_out), 32'(m_spins));
        chk("flip_count", 32'(bus.flip_count), (m_flips > 65535) ? 32'd65535 : 32'(m_flips));
        chk("sweeps_done", 32'(bus.sweeps_done), 32'(m_sweeps));
        chk("energy_out", 32'(bus.energy_out), 32'(m_energy) & ((32'd1 << EW) - 1));
        mon_active = 1'b0;
      end
    end
  end

  task automatic set_j(input int r_off, input int r_diag, input int c_off, input int c_diag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        jr[i][j] = (i == j) ? r_diag : r_off;
        jc[i][j] = (i == j) ? c_diag : c_off;
      end
  endtask

  int run_no = 0;
  task automatic run_case(input logic [N-1:0] sp, input bit byp, input int dly,
                          input int stop_ser, input bit pulse);
    model(sp, byp, pulse ? -1 : stop_ser);
    exp_rows    = m_rows;
    row_delay   = dly;
    stop_serial = stop_ser;
    stop_pulse  = pulse;
    exp_done    = 1 + m_rows.size() * (CH + 2 + dly);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.bypass   = byp;
    bus.spins_in = sp;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.bypass   = 1'($urandom);
    bus.spins_in = N'($urandom);
    got_done   = -1;
    mon_cyc    = 0;
    mon_active = 1'b1;
    for (int k = 0; k < exp_done + 20 && mon_active; k++) begin
      @(negedge clk);
      bus.start = (k == 2);
    end
    bus.start = 1'b0;
    if (mon_active) begin
      chk("run_timeout", 32'(mon_cyc), 32'(exp_done));
      mon_active = 1'b0;
    end
    @(negedge clk);
    chk("idle_after", {30'd0, bus.busy, bus.done}, 32'h0);
    chk("energy_held", 32'(bus.energy_out), 32'(m_energy) & ((32'd1 << EW) - 1));
    chk("rows_left", 32'(exp_rows.size()), 32'd0);
    exp_rows.delete();
    stop_serial = -1;
    $display("run %0d: spins_in=%b bypass=%0d delay=%0d stop_row=%0d pulse=%0d rows=%0d done_cycle=%0d energy=%0d",
             run_no, sp, byp, dly, stop_ser, pulse, m_rows.size(), got_done, m_energy);
    run_no++;
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.bypass   = 1'b0;
    bus.spins_in = '0;
    set_j(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_row_req", 32'(bus.row_req), 32'd0);
    chk("rst_outputs", 32'(bus.spins_out) | 32'(bus.energy_out) | 32'(bus.flip_count)
                       | 32'(bus.sweeps_done), 32'd0);
    reset = 1'b0;

    // all-zero couplings: every field is 0, so every spin goes to bit 1
    set_j(0, 0, 0, 0);
    run_case(4'b0000, 1'b0, 0, -1, 1'b0);
    chk("lit_zero_spins", 32'(bus.spins_out), 32'hF);
    chk("lit_zero_flips", 32'(bus.flip_count), 32'd4);
    chk("lit_zero_sweeps", 32'(bus.sweeps_done), 32'd2);
    chk("lit_zero_done", 32'(got_done), 32'd49);

    // bypass energy with row weights only; diagonal values must be masked
    set_j(1, 7, 0, -8);
    run_case(4'b0000, 1'b1, 0, -1, 1'b0);
    chk("lit_byp_energy", 32'(bus.energy_out), 32'd12);
    chk("lit_byp_spins", 32'(bus.spins_out), 32'd0);
    chk("lit_byp_sweeps", 32'(bus.sweeps_done), 32'd0);
    chk("lit_byp_done", 32'(got_done), 32'd17);

    run_case(4'b0000, 1'b1, 5, -1, 1'b0);
    chk("lit_slow_energy", 32'(bus.energy_out), 32'd12);
    chk("lit_slow_done", 32'(got_done), 32'd37);

    // antiferro: fields all -3, nothing flips, energy -12
    set_j(-1, 0, 0, 0);
    run_case(4'b0000, 1'b0, 0, -1, 1'b0);
    chk("lit_af_sweeps", 32'(bus.sweeps_done), 32'd1);
    chk("lit_af_energy", 32'(bus.energy_out), 32'h000F_FFF4);

    // stop held into row 1 update ends sweeping; a pulse inside ACC does not
    set_j(0, 0, 0, 0);
    run_case(4'b0000, 1'b0, 0, 1, 1'b0);
    chk("lit_stop_spins", 32'(bus.spins_out), 32'h3);
    chk("lit_stop_sweeps", 32'(bus.sweeps_done), 32'd0);
    chk("lit_stop_done", 32'(got_done), 32'd25);
    run_case(4'b0000, 1'b0, 0, 1, 1'b1);
    chk("lit_pulse_done", 32'(got_done), 32'd49);

    // reset in the middle of a run, while row 2 is being requested
    model(4'b0000, 1'b0, -1);
    exp_rows = m_rows;
    row_delay = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (bus.row_req && bus.row_addr == 2'd2) break;
      end
      chk("reach_row2", 32'(k < 100), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_row_req", 32'(bus.row_req), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_outputs", 32'(bus.spins_out) | 32'(bus.energy_out) | 32'(bus.flip_count)
                          | 32'(bus.sweeps_done), 32'd0);
    reset = 1'b0;
    exp_rows.delete();
    run_case(4'b0000, 1'b0, 0, -1, 1'b0);
    chk("lit_after_rst_done", 32'(got_done), 32'd49);

    // randomized couplings, spins, modes, latencies and stop points
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          jr[i][j] = int'($urandom_range(15)) - 8;
          jc[i][j] = int'($urandom_range(15)) - 8;
        end
      run_case(N'($urandom), ($urandom_range(3) == 0), int'($urandom_range(2)),
               ($urandom_range(2) == 0) ? int'($urandom_range(7)) : -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
